axi4_lite_slave_regs: RTL and testbench

AXI4-Lite slave register bank that terminates transactions issued by the team's AXI4-Lite master. Holds NUM_REGS word-wide control/status registers behind independent write and read channel FSMs. Accepts AW and W in either order and honours byte strobes. Exposes the register contents and per-register write pulses to downstream logic.

---
 rtl/axi4_lite_slave_regs.sv | 204 ++++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank with independent write/read FSMs; AW and W accepted in either order.
// Optional AXI4L_SLV_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [STRB_WIDTH-1:0]          S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int OFS   = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI4L_SLV_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic {W_COLLECT = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, wr_commit, wr_in_range, rd_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  // A channel completing this cycle is used directly, so the write needs no extra cycle.
  assign wr_commit   = (w_state_q == W_COLLECT) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_addr     = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data     = w_held_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb     = w_held_q ? w_strb_q : S_AXI_WSTRB;
  assign wr_in_range = wr_addr < ADDR_LIMIT;
  assign wr_idx      = wr_addr[IDX_W+OFS-1:OFS];
  assign rd_in_range = S_AXI_ARADDR < ADDR_LIMIT;
  assign rd_idx      = S_AXI_ARADDR[IDX_W+OFS-1:OFS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q  <= W_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_COLLECT: if (wr_commit) w_state_d = W_RESP;
      W_RESP:    if (bvalid_q & S_AXI_BREADY) w_state_d = W_COLLECT;
    endcase
  end

  always_comb begin
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_OOR;
      if (wr_in_range) begin
        wr_pulse_d[wr_idx] = 1'b1;
        for (int b = 0; b < STRB_WIDTH; b++)
          if (wr_strb[b]) regs_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
    bvalid_d  = (w_state_d == W_RESP);
    awready_d = (w_state_d == W_COLLECT) & ~aw_held_d;
    wready_d  = (w_state_d == W_COLLECT) & ~w_held_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (rvalid_q & S_AXI_RREADY) r_state_d = R_IDLE;
    endcase
  end

  // Reads sample regs_q, so a same-edge write is not visible to them.
  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_in_range ? regs_q[rd_idx] : '0;
      rresp_d = rd_in_range ? RESP_OKAY : RESP_OOR;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign reg_wr_pulse  = wr_pulse_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: directed vector table, corner sequences, random traffic vs. a register-array model.
module tb_axi4_lite_slave_regs;
  localparam int AW = 32, DW = 32, SW = 4, NR = 16;
`ifdef AXI4L_SLV_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic             S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_ARVALID = 1'b0;
  logic             S_AXI_BREADY = 1'b0, S_AXI_RREADY = 1'b0;
  logic [DW-1:0]    S_AXI_WDATA = '0;
  logic [SW-1:0]    S_AXI_WSTRB = '0;
  logic             S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
  logic [1:0]       S_AXI_BRESP, S_AXI_RRESP;
  logic [DW-1:0]    S_AXI_RDATA;
  logic [NR*DW-1:0] regs_out;
  logic [NR-1:0]    reg_wr_pulse;

  axi4_lite_slave_regs dut (
    .clk(clk), .reset_n(reset_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_out(regs_out), .reg_wr_pulse(reg_wr_pulse)
  );

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [NR];

  typedef struct {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [SW-1:0] ws;
    int            aw_dly;
    int            w_dly;
    int            b_dly;
    logic [AW-1:0] ra;
    int            r_dly;
    logic [DW-1:0] exp_rd;
    bit            rd_oor;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [AW-1:0] a);
    return a < NR * SW;
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    int t = 0;
    logic [NR-1:0] exp_pulse = '0;
    logic [1:0] exp_resp = in_rng(addr) ? 2'b00 : OOR_RESP;
    logic [AW-1:0] a = addr;
    if (in_rng(addr)) begin
      exp_pulse[a[5:2]] = 1'b1;
      for (int b = 0; b < SW; b++) if (strb[b]) model[a[5:2]][b*8 +: 8] = data[b*8 +: 8];
    end
    while (!(aw_done && w_done) && t < 100) begin
      @(negedge clk);
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = !aw_done && t >= aw_dly;
      S_AXI_WVALID  = !w_done && t >= w_dly;
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      chk("bvalid_early", S_AXI_BVALID, 1'b0);
      @(posedge clk);
      aw_done |= aw_now;
      w_done  |= w_now;
      t++;
    end
    chk("wr_handshake_timeout", aw_done && w_done, 1'b1);
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("bvalid_latency", S_AXI_BVALID, 1'b1);
    chk("bresp", S_AXI_BRESP, exp_resp);
    chk("wr_pulse", reg_wr_pulse, exp_pulse);
    chk("regs_out_after_wr", regs_out, model_flat());
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      chk("bvalid_hold", S_AXI_BVALID, 1'b1);
      chk("bresp_hold", S_AXI_BRESP, exp_resp);
      chk("wr_readies_stall", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
      chk("wr_pulse_single", reg_wr_pulse, '0);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clear", S_AXI_BVALID, 1'b0);
    chk("wr_readies_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int ar_dly, input int r_dly,
                          input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
    bit done = 0, now;
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = t >= ar_dly;
      now = S_AXI_ARVALID && S_AXI_ARREADY;
      chk("rvalid_early", S_AXI_RVALID, 1'b0);
      @(posedge clk);
      done = now;
      t++;
    end
    chk("rd_handshake_timeout", done, 1'b1);
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    chk("rvalid_latency", S_AXI_RVALID, 1'b1);
    chk("rdata", S_AXI_RDATA, exp_data);
    chk("rresp", S_AXI_RRESP, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("rvalid_hold", S_AXI_RVALID, 1'b1);
      chk("rdata_hold", S_AXI_RDATA, exp_data);
      chk("arready_stall", S_AXI_ARREADY, 1'b0);
    end
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
    chk("rvalid_clear", S_AXI_RVALID, 1'b0);
    chk("arready_back", S_AXI_ARREADY, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] old_val;
    logic [AW-1:0] ra;
    int nb, nr;
    for (int i = 0; i < NR; i++) model[i] = '0;

    vecs[0] = '{32'h08,  32'hDEADBEEF, 4'hF, 0, 3, 0, 32'h08, 0, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{32'h04,  32'h12345678, 4'hF, 1, 0, 5, 32'h04, 5, 32'h12345678, 1'b0};
    vecs[2] = '{32'h04,  32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h04, 0, 32'hCAFEF00D, 1'b0};
    vecs[3] = '{32'h0C,  32'h11223344, 4'hF, 0, 0, 0, 32'h0C, 0, 32'h11223344, 1'b0};
    vecs[4] = '{32'h0C,  32'hAABBCCDD, 4'h5, 2, 1, 0, 32'h0C, 1, 32'h11BB33DD, 1'b0};
    vecs[5] = '{32'h10,  32'hFFFFFFFF, 4'h0, 0, 0, 0, 32'h10, 0, 32'h00000000, 1'b0};
    vecs[6] = '{32'h40,  32'h55555555, 4'hF, 0, 0, 0, 32'h40, 0, 32'h00000000, 1'b1};
    vecs[7] = '{32'h3C,  32'h80000001, 4'hF, 1, 1, 2, 32'h00, 0, 32'h00000000, 1'b0};
    vecs[8] = '{32'h0B,  32'h0F0F0F0F, 4'h3, 0, 0, 0, 32'h3C, 0, 32'h80000001, 1'b0};
    vecs[9] = '{32'h100, 32'h77777777, 4'hF, 0, 0, 0, 32'h09, 0, 32'hDEAD0F0F, 1'b0};

    #12;
    chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("rst_resps", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0000);
    chk("rst_rdata", S_AXI_RDATA, '0);
    chk("rst_regs", regs_out, '0);
    chk("rst_pulse", reg_wr_pulse, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("readies_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    foreach (vecs[i]) begin
      axi_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly);
      axi_read(vecs[i].ra, 0, vecs[i].r_dly, vecs[i].exp_rd, vecs[i].rd_oor ? OOR_RESP : 2'b00);
    end

    // Write and read of the same register committing on one edge.
    old_val = model[5];
    @(negedge clk);
    S_AXI_AWADDR = 32'h14; S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h14;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    chk("same_edge_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    model[5] = 32'h5A5A5A5A;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    chk("same_edge_rdata_old", S_AXI_RDATA, old_val);
    chk("same_edge_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b11);
    chk("same_edge_regs", regs_out, model_flat());
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;

    // Back-to-back with ready held high: one transfer per channel every 2 cycles.
    S_AXI_AWADDR = 32'h1C; S_AXI_WDATA = 32'h00000077; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 32'h08;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    model[7] = 32'h00000077;
    nb = 0; nr = 0;
    repeat (8) begin
      @(negedge clk);
      if (S_AXI_BVALID) nb++;
      if (S_AXI_RVALID) nr++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    chk("b2b_writes", nb, 4);
    chk("b2b_reads", nr, 4);
    chk("b2b_rdata", S_AXI_RDATA, model[2]);
    chk("b2b_regs", regs_out, model_flat());
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      axi_write($urandom_range(0, 79), $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      ra = $urandom_range(0, 79);
      axi_read(ra, $urandom_range(0, 2), $urandom_range(0, 2),
               in_rng(ra) ? model[ra[5:2]] : '0, in_rng(ra) ? 2'b00 : OOR_RESP);
    end

    // Reset while a write response is pending.
    @(negedge clk);
    S_AXI_AWADDR = 32'h04; S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("pre_rst_bvalid", S_AXI_BVALID, 1'b1);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
    chk("mid_rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    chk("mid_rst_regs", regs_out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("readies_low_at_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
    @(negedge clk);
    chk("readies_after_release", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    axi_read(32'h04, 0, 0, 32'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
